// File: rtl/mem_xfer_ctrl_if.sv
// Control/strobe bundle between the top-level sequencer and mem_xfer_ctrl.
// The master drives start/cont/pause; the slave drives the memory strobes and status.
interface mem_xfer_ctrl_if #(
  parameter int ADDR_A_W = 4,
  parameter int ADDR_B_W = 3
);
  logic                start;
  logic                cont;
  logic                pause;
  logic                wea;
  logic                rea;
  logic [ADDR_A_W-1:0] addr_a;
  logic                web;
  logic [ADDR_B_W-1:0] addr_b;
  logic                busy;
  logic                done;
  logic [2:0]          phase;

  modport master (
    output start, cont, pause,
    input  wea, rea, addr_a, web, addr_b, busy, done, phase
  );

  modport slave (
    input  start, cont, pause,
    output wea, rea, addr_a, web, addr_b, busy, done, phase
  );
endinterface

// File: rtl/mem_xfer_ctrl.sv
// Fill/gap/transfer sequencer for the A->B packing datapath: fills A, waits,
// then reads A back and writes one B word per PACK A words.
module mem_xfer_ctrl #(
  parameter int ADDR_A_W = 4,
  parameter int ADDR_B_W = 3,
  parameter int FILL_LEN = 8,
  parameter int PACK     = 2,
  parameter int GAP_LEN  = 2
) (
  input  logic           clock,
  input  logic           Reset,
  mem_xfer_ctrl_if.slave bus
);
  localparam int CW = ADDR_A_W + 1;
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [CW-1:0] CLAST = CW'(FILL_LEN - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    GAP   = 3'd2,
    XFER  = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [GW-1:0]       gcnt;
  logic                wb_pend;
  logic [ADDR_B_W-1:0] addr_b_q;
  logic                adv;

  assign adv = (state inside {FILL, GAP, XFER, FLUSH}) && !bus.pause;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      wb_pend  <= 1'b0;
      addr_b_q <= '0;
    end else begin
      if (wb_pend && !bus.pause) addr_b_q <= addr_b_q + 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          state <= FILL;
          cnt   <= '0;
        end
        FILL: if (adv) begin
          if (cnt == CLAST) begin
            cnt   <= '0;
            gcnt  <= '0;
            state <= (GAP_LEN == 0) ? XFER : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: if (adv) begin
          if (gcnt == GLAST) begin
            state <= XFER;
            cnt   <= '0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        XFER: if (adv) begin
          // B write lands the cycle after the last A word of each group is read
          wb_pend <= ((int'(cnt) % PACK) == (PACK - 1));
          if (cnt == CLAST) begin
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: if (adv) begin
          wb_pend <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          addr_b_q <= '0;
          cnt      <= '0;
          state    <= (bus.start || bus.cont) ? FILL : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while Reset is asserted, even mid-run.
  always_comb begin
    bus.wea    = !Reset && (state == FILL) && !bus.pause;
    bus.rea    = !Reset && (state == XFER) && !bus.pause;
    bus.web    = !Reset && wb_pend && !bus.pause;
    bus.addr_a = (!Reset && (state == FILL || state == XFER)) ? cnt[ADDR_A_W-1:0] : '0;
    bus.addr_b = Reset ? '0 : addr_b_q;
    bus.busy   = !Reset && (state inside {FILL, GAP, XFER, FLUSH});
    bus.done   = !Reset && (state == DONE);
    bus.phase  = Reset ? 3'd0 : state;
  end
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed scoreboard bench: per-cycle expectations are derived from the run
// schedule (fill, gap, transfer, flush, done) and compared cycle by cycle.
module tb_mem_xfer_ctrl;
  logic clock = 1'b0;
  logic Reset = 1'b1;
  always #5 clock = ~clock;

  mem_xfer_ctrl_if #(.ADDR_A_W(4), .ADDR_B_W(3)) if0 ();
  mem_xfer_ctrl_if #(.ADDR_A_W(4), .ADDR_B_W(3)) if1 ();

  mem_xfer_ctrl #(.ADDR_A_W(4), .ADDR_B_W(3), .FILL_LEN(8), .PACK(2), .GAP_LEN(2))
    u_dut0 (.clock(clock), .Reset(Reset), .bus(if0));
  mem_xfer_ctrl #(.ADDR_A_W(4), .ADDR_B_W(3), .FILL_LEN(6), .PACK(3), .GAP_LEN(0))
    u_dut1 (.clock(clock), .Reset(Reset), .bus(if1));

  typedef struct packed {
    logic [2:0] phase;
    logic       busy;
    logic       done;
    logic       wea;
    logic       rea;
    logic       web;
    logic [3:0] addr_a;
    logic [2:0] addr_b;
  } obs_t;

  obs_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Expected outputs for unpaused step k of a run (step 0 = first FILL cycle).
  function automatic obs_t step_exp(input int F, input int P, input int G, input int k);
    obs_t e;
    int   j;
    e = '0;
    if (k < F) begin
      e.phase = 3'd1; e.busy = 1'b1; e.wea = 1'b1; e.addr_a = 4'(k);
    end else if (k < F + G) begin
      e.phase = 3'd2; e.busy = 1'b1;
    end else if (k < 2*F + G) begin
      j = k - F - G;
      e.phase = 3'd3; e.busy = 1'b1; e.rea = 1'b1; e.addr_a = 4'(j);
      if (j > 0 && (j % P) == 0) begin
        e.web = 1'b1; e.addr_b = 3'(j / P - 1);
      end
    end else if (k == 2*F + G) begin
      e.phase = 3'd4; e.busy = 1'b1; e.web = 1'b1; e.addr_b = 3'(F / P - 1);
    end else begin
      e.phase = 3'd5; e.done = 1'b1;
    end
    return e;
  endfunction

  // Push expectations for one run starting at cycle c0; cycles beyond 'last' are dropped.
  task automatic build_run(input int F, input int P, input int G, input int c0,
                           input int pz, input int last, input bit lead, input bit trail);
    int   c;
    int   k;
    obs_t e;
    c = c0;
    k = 0;
    if (lead) begin
      if (c <= last) exp_q.push_back('0);
      c++;
    end
    while (k < 2*F + G + 2) begin
      e = step_exp(F, P, G, k);
      if (c == pz && e.phase != 3'd5) begin
        e.wea = 1'b0; e.rea = 1'b0; e.web = 1'b0; e.addr_b = 3'd0;
      end else begin
        k++;
      end
      if (c <= last) exp_q.push_back(e);
      c++;
    end
    if (trail && c <= last) exp_q.push_back('0);
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) begin
      o = {if0.phase, if0.busy, if0.done, if0.wea, if0.rea, if0.web, if0.addr_a, if0.addr_b};
    end else begin
      o = {if1.phase, if1.busy, if1.done, if1.wea, if1.rea, if1.web, if1.addr_a, if1.addr_b};
    end
    if (!o.web) o.addr_b = 3'd0;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t obs, input obs_t expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic do_reset();
    @(negedge clock);
    Reset = 1'b1;
    if0.start = 1'b0; if0.cont = 1'b0; if0.pause = 1'b0;
    if1.start = 1'b0; if1.cont = 1'b0; if1.pause = 1'b0;
    @(negedge clock);
    #1;
    check("reset_dut0", sample(0), '0);
    check("reset_dut1", sample(1), '0);
  endtask

  // Drive n cycles on the selected DUT and compare each against the scoreboard.
  task automatic drive(input string tag, input int n, input int sel, input int s0,
                       input int s1, input int s2, input int pz, input int rs, input bit cn);
    obs_t o;
    obs_t e;
    logic st;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      st    = (c == s0) || (c == s1) || (c == s2);
      Reset = (c == rs);
      if (sel == 0) begin
        if0.start = st; if0.pause = (c == pz); if0.cont = cn;
      end else begin
        if1.start = st; if1.pause = (c == pz); if1.cont = cn;
      end
      #1;
      o = sample(sel);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $error("FAIL %s: cycle %0d observed %h expected <scoreboard empty>", tag, c, o);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s@%0d", tag, c), o, e);
      end
    end
    if (exp_q.size() != 0) begin
      total_cnt++;
      $error("FAIL %s: %0d leftover expected entries, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.cont = 1'b0; if0.pause = 1'b0;
    if1.start = 1'b0; if1.cont = 1'b0; if1.pause = 1'b0;

    // Basic run on defaults: done at cycle 20, idle at 21.
    do_reset();
    build_run(8, 2, 2, 0, -1, 999, 1'b1, 1'b1);
    drive("basic", 22, 0, 0, -1, -1, -1, -1, 1'b0);

    // Pause in cycle 12 stretches the run by one cycle.
    do_reset();
    build_run(8, 2, 2, 0, 12, 999, 1'b1, 1'b1);
    drive("pause", 23, 0, 0, -1, -1, 12, -1, 1'b0);

    // Continuous mode: back-to-back runs with done at 20 and 40.
    do_reset();
    build_run(8, 2, 2, 0, -1, 999, 1'b1, 1'b0);
    build_run(8, 2, 2, 21, -1, 999, 1'b0, 1'b0);
    drive("cont", 41, 0, 0, -1, -1, -1, -1, 1'b1);

    // Reset mid-transfer at cycle 14, then a fresh run started at cycle 20.
    do_reset();
    build_run(8, 2, 2, 0, -1, 13, 1'b1, 1'b0);
    for (int i = 14; i <= 20; i++) exp_q.push_back('0);
    build_run(8, 2, 2, 21, -1, 999, 1'b0, 1'b1);
    drive("abort", 42, 0, 0, 20, -1, -1, 14, 1'b0);

    // FILL_LEN=6, PACK=3, no gap: web at 10 and 13, done at 14.
    do_reset();
    build_run(6, 3, 0, 0, -1, 999, 1'b1, 1'b1);
    drive("pack3", 16, 1, 0, -1, -1, -1, -1, 1'b0);

    // Start pulses mid-run are ignored.
    do_reset();
    build_run(8, 2, 2, 0, -1, 999, 1'b1, 1'b1);
    drive("ign_start", 22, 0, 0, 3, 15, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
